// File: rtl/poly_oscillator_pkg.sv
// osc_pkg: shared types and sizing helpers for the poly_oscillator slice.
// Voice index / mix widths are derived from the voice count via vidx_w().
package osc_pkg;

    localparam int NUM_VOICES_DEF = 4;
    localparam int PHASE_W_DEF    = 32;
    localparam int OUT_W_DEF      = 16;

    function automatic int vidx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int VIDX_W = vidx_w(NUM_VOICES_DEF);
    localparam int MIX_W  = OUT_W_DEF + VIDX_W;

    typedef enum logic [1:0] {
        WAVE_SAW    = 2'd0,
        WAVE_SQUARE = 2'd1,
        WAVE_TRI    = 2'd2,
        WAVE_OFF    = 2'd3
    } wave_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_FLUSH = 2'd2
    } osc_state_t;

endpackage

// File: rtl/poly_oscillator_if.sv
// poly_oscillator_if: config inputs, sample-rate tick and sample/mix outputs of the oscillator.
// Strobe semantics: there is no back-pressure; Voice_valid/Mix_valid are single-cycle strobes and
// the sink must take Voice_out/Voice_idx/Mix_out in the cycle the matching strobe is high.
interface poly_oscillator_if
    import osc_pkg::*;
#(
    parameter int NUM_VOICES = NUM_VOICES_DEF,
    parameter int PHASE_W    = PHASE_W_DEF,
    parameter int OUT_W      = OUT_W_DEF
);
    localparam int IW = vidx_w(NUM_VOICES);
    localparam int MW = OUT_W + IW;

    logic                 Osc_ce;
    logic                 Syn_clk;
    logic                 Cfg_we;
    logic [IW-1:0]        Cfg_addr;
    logic [PHASE_W-1:0]   Cfg_freq;
    logic [1:0]           Cfg_wave;
    logic                 Cfg_sync;

    logic signed [OUT_W-1:0] Voice_out;
    logic [IW-1:0]           Voice_idx;
    logic                    Voice_valid;
    logic signed [MW-1:0]    Mix_out;
    logic                    Mix_valid;
    logic                    Busy;
    logic                    Overrun;
    osc_state_t              Dbg_state;

    modport master (
        output Osc_ce, Syn_clk, Cfg_we, Cfg_addr, Cfg_freq, Cfg_wave, Cfg_sync,
        input  Voice_out, Voice_idx, Voice_valid, Mix_out, Mix_valid, Busy, Overrun, Dbg_state
    );

    modport slave (
        input  Osc_ce, Syn_clk, Cfg_we, Cfg_addr, Cfg_freq, Cfg_wave, Cfg_sync,
        output Voice_out, Voice_idx, Voice_valid, Mix_out, Mix_valid, Busy, Overrun, Dbg_state
    );

endinterface

// File: rtl/poly_oscillator_wave_shaper.sv
// osc_wave_shaper: maps the top OUT_W+1 phase bits to a signed sample, registered (1-cycle latency).
// The register only loads when i_en is high so the sample holds between sweeps and under clock-enable.
module osc_wave_shaper
    import osc_pkg::*;
#(
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_en,
    input  logic [OUT_W:0]          i_phase_top,
    input  wave_t                   i_wave,
    output logic signed [OUT_W-1:0] o_sample
);
    localparam logic [OUT_W-1:0] SQ_POS = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] SQ_NEG = ~SQ_POS + 1'b1;

    logic [OUT_W-1:0] w_saw;
    logic [OUT_W-1:0] w_tri_fold;
    logic [OUT_W-1:0] w_shape;

    // Inverting the MSB turns the unsigned ramp into a zero-centred signed one.
    assign w_saw      = {~i_phase_top[OUT_W], i_phase_top[OUT_W-1:1]};
    assign w_tri_fold = i_phase_top[OUT_W] ? ~i_phase_top[OUT_W-1:0] : i_phase_top[OUT_W-1:0];

    always_comb begin
        w_shape = '0;
        case (i_wave)
            WAVE_SAW:    w_shape = w_saw;
            WAVE_SQUARE: w_shape = i_phase_top[OUT_W] ? SQ_NEG : SQ_POS;
            WAVE_TRI:    w_shape = {~w_tri_fold[OUT_W-1], w_tri_fold[OUT_W-2:0]};
            default:     w_shape = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_sample <= '0;
        end else if (i_en) begin
            o_sample <= w_shape;
        end
    end

endmodule

// File: rtl/poly_oscillator.sv
// poly_oscillator: time-multiplexed N-voice phase-accumulator oscillator with a summed mix output.
// Define OSC_SYNC_EN to enable hard sync of voice v to the carry-out of voice v-1.
module poly_oscillator
    import osc_pkg::*;
#(
    parameter int NUM_VOICES = NUM_VOICES_DEF,
    parameter int PHASE_W    = PHASE_W_DEF,
    parameter int OUT_W      = OUT_W_DEF
) (
    input  logic             Sys_clk,
    input  logic             Osc_rst_n,
    poly_oscillator_if.slave bus
);
    localparam int IW = vidx_w(NUM_VOICES);
    localparam int MW = OUT_W + IW;
    localparam logic [IW-1:0] LAST = IW'(NUM_VOICES - 1);

    logic [PHASE_W-1:0] r_phase [NUM_VOICES];
    logic [PHASE_W-1:0] r_inc   [NUM_VOICES];
    wave_t              r_wave  [NUM_VOICES];

    logic       r_syn_meta, r_syn_sync, r_syn_prev;
    osc_state_t r_state, w_state_nxt;
    logic [IW-1:0] r_cnt, w_cnt_nxt;
    logic          r_vld;
    logic [IW-1:0] r_idx;
    logic [MW-1:0] r_acc;
    logic signed [MW-1:0] r_mix;
    logic          r_mix_valid;
    logic          r_overrun;

    logic               w_tick, w_busy, w_start, w_sweep, w_last, w_do_sync;
    logic [PHASE_W-1:0] w_sum, w_new_phase;
    logic signed [OUT_W-1:0] w_sample;
    logic [MW-1:0]      w_sample_ext;

    assign w_tick  = r_syn_sync & ~r_syn_prev;
    assign w_busy  = (r_state != ST_IDLE) | r_mix_valid;
    assign w_start = bus.Osc_ce & w_tick & ~w_busy;
    assign w_sweep = bus.Osc_ce & (r_state == ST_SWEEP);
    assign w_last  = (r_cnt == LAST);

`ifdef OSC_SYNC_EN
    logic r_sync [NUM_VOICES];
    logic r_carry;
    logic w_carry;

    assign {w_carry, w_sum} = {1'b0, r_phase[r_cnt]} + {1'b0, r_inc[r_cnt]};
    // r_carry holds the wrap of the voice processed in the previous sweep cycle.
    assign w_do_sync = r_sync[r_cnt] & r_carry & (r_cnt != '0);

    always_ff @(posedge Sys_clk or negedge Osc_rst_n) begin
        if (!Osc_rst_n) begin
            r_carry <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) r_sync[i] <= 1'b0;
        end else begin
            if (w_sweep) r_carry <= w_carry;
            if (bus.Cfg_we) r_sync[bus.Cfg_addr] <= bus.Cfg_sync;
        end
    end
`else
    assign w_sum     = r_phase[r_cnt] + r_inc[r_cnt];
    assign w_do_sync = 1'b0;
`endif

    assign w_new_phase  = w_do_sync ? '0 : w_sum;
    assign w_sample_ext = {{IW{w_sample[OUT_W-1]}}, w_sample};

    always_ff @(posedge Sys_clk or negedge Osc_rst_n) begin
        if (!Osc_rst_n) begin
            r_syn_meta <= 1'b0;
            r_syn_sync <= 1'b0;
            r_syn_prev <= 1'b0;
        end else begin
            r_syn_meta <= bus.Syn_clk;
            r_syn_sync <= r_syn_meta;
            r_syn_prev <= r_syn_sync;
        end
    end

    // Config writes land regardless of Osc_ce; the sweep reads the pre-edge values.
    always_ff @(posedge Sys_clk or negedge Osc_rst_n) begin
        if (!Osc_rst_n) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                r_inc[i]  <= '0;
                r_wave[i] <= WAVE_SAW;
            end
        end else if (bus.Cfg_we) begin
            r_inc[bus.Cfg_addr]  <= bus.Cfg_freq;
            r_wave[bus.Cfg_addr] <= wave_t'(bus.Cfg_wave);
        end
    end

    always_ff @(posedge Sys_clk or negedge Osc_rst_n) begin
        if (!Osc_rst_n) begin
            for (int i = 0; i < NUM_VOICES; i++) r_phase[i] <= '0;
        end else if (w_sweep) begin
            r_phase[r_cnt] <= w_new_phase;
        end
    end

    always_ff @(posedge Sys_clk or negedge Osc_rst_n) begin
        if (!Osc_rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (bus.Osc_ce) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        w_state_nxt = ST_SWEEP;
                        w_cnt_nxt   = '0;
                    end
                end
                ST_SWEEP: begin
                    if (w_last) w_state_nxt = ST_FLUSH;
                    else        w_cnt_nxt   = r_cnt + 1'b1;
                end
                ST_FLUSH: w_state_nxt = ST_IDLE;
                default:  w_state_nxt = ST_IDLE;
            endcase
        end
    end

    osc_wave_shaper #(.OUT_W(OUT_W)) u_shaper (
        .i_clk       (Sys_clk),
        .i_rst_n     (Osc_rst_n),
        .i_en        (w_sweep),
        .i_phase_top (w_new_phase[PHASE_W-1 -: OUT_W+1]),
        .i_wave      (r_wave[r_cnt]),
        .o_sample    (w_sample)
    );

    always_ff @(posedge Sys_clk or negedge Osc_rst_n) begin
        if (!Osc_rst_n) begin
            r_vld       <= 1'b0;
            r_idx       <= '0;
            r_acc       <= '0;
            r_mix       <= '0;
            r_mix_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else if (bus.Osc_ce) begin
            r_vld       <= (r_state == ST_SWEEP);
            r_mix_valid <= r_vld && (r_idx == LAST);
            if (r_state == ST_SWEEP) r_idx <= r_cnt;
            if (w_start)      r_acc <= '0;
            else if (r_vld)   r_acc <= r_acc + w_sample_ext;
            if (r_vld && (r_idx == LAST)) r_mix <= r_acc + w_sample_ext;
            if (w_tick && w_busy) r_overrun <= 1'b1;
        end
    end

    assign bus.Voice_out   = w_sample;
    assign bus.Voice_idx   = r_idx;
    assign bus.Voice_valid = r_vld & bus.Osc_ce;
    assign bus.Mix_out     = r_mix;
    assign bus.Mix_valid   = r_mix_valid & bus.Osc_ce;
    assign bus.Busy        = w_busy;
    assign bus.Overrun     = r_overrun;
    assign bus.Dbg_state   = r_state;

endmodule
